// File: rtl/note_sequence_mux.sv
// note_sequence_mux
//   Note-position sequencer. It steps through NUM_NOTES packed note slots and
//   presents one DATA_W value per step, paced by step_en. It sits between the
//   per-note position registers and the note renderer / audio trigger logic.
//   It supports a programmable length, one-shot and loop modes, start/stop
//   control and status flags.
//
// Ports
//   clk_in     single clock, all logic on the rising edge
//   rst        synchronous, active-high reset; overrides every other input
//   start      begin (or restart) a sequence from slot 0, latching len
//   stop       abort the running sequence (no done pulse)
//   step_en    advance one slot this cycle (ignored while idle)
//   loop_mode  1: wrap to slot 0 after the last slot, 0: one-shot
//   len        active slot count; 0 or > NUM_NOTES selects NUM_NOTES
//   x_in_flat  slot k at bits [k*DATA_W +: DATA_W], sampled at step time
//   x_out      registered note value
//   x_valid    1-cycle pulse when x_out updates
//   counter    index of the next slot to emit
//   busy       high while a sequence is running
//   wrap       1-cycle pulse, coincident with x_valid, when loop mode wraps
//   done       1-cycle pulse, coincident with x_valid, on one-shot completion
//
// Priority in every cycle: rst > stop > start > step_en.
// All outputs are registered; no combinational path from inputs to outputs.

module note_sequence_mux #(
  parameter int DATA_W    = 10,
  parameter int NUM_NOTES = 32,
  parameter int IDX_W     = $clog2(NUM_NOTES + 1)
) (
  input  logic                        clk_in,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        step_en,
  input  logic                        loop_mode,
  input  logic [IDX_W-1:0]            len,
  input  logic [NUM_NOTES*DATA_W-1:0] x_in_flat,
  output logic [DATA_W-1:0]           x_out,
  output logic                        x_valid,
  output logic [IDX_W-1:0]            counter,
  output logic                        busy,
  output logic                        wrap,
  output logic                        done
);

  // Width of a slot index; counter stays below NUM_NOTES while running, so
  // its low SEL_W bits address the slot directly.
  localparam int SEL_W = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;

  localparam logic [IDX_W-1:0] NOTES_W = IDX_W'(NUM_NOTES);
  localparam logic [IDX_W-1:0] ONE_W   = IDX_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_n;

  logic [IDX_W-1:0]  len_q, len_n;
  logic [IDX_W-1:0]  counter_n;
  logic [DATA_W-1:0] x_out_n;
  logic              x_valid_n;
  logic              wrap_n;
  logic              done_n;

  logic [IDX_W-1:0]  len_eff;
  logic [IDX_W-1:0]  last_idx;
  logic [DATA_W-1:0] slots [NUM_NOTES];
  logic [DATA_W-1:0] cur_slot;

  // Unpack the flat slot bus into an indexable array.
  always_comb begin
    for (int unsigned k = 0; k < NUM_NOTES; k++) begin
      slots[k] = x_in_flat[k*DATA_W +: DATA_W];
    end
  end

  assign cur_slot = slots[counter[SEL_W-1:0]];

  // Out-of-range or zero length means "use every slot".
  assign len_eff  = ((len == '0) || (len > NOTES_W)) ? NOTES_W : len;
  assign last_idx = len_q - ONE_W;

  always_comb begin
    state_n   = state;
    len_n     = len_q;
    counter_n = counter;
    x_out_n   = x_out;
    x_valid_n = 1'b0;
    wrap_n    = 1'b0;
    done_n    = 1'b0;

    unique case (state)
      IDLE: begin
        // stop outranks start even while idle; step_en is ignored here.
        if (!stop && start) begin
          len_n     = len_eff;
          counter_n = '0;
          state_n   = RUN;
        end
      end

      RUN: begin
        if (stop) begin
          counter_n = '0;
          state_n   = IDLE;
        end else if (start) begin
          // Restart: a simultaneous step_en is dropped.
          len_n     = len_eff;
          counter_n = '0;
        end else if (step_en) begin
          x_out_n   = cur_slot;
          x_valid_n = 1'b1;
          if (counter == last_idx) begin
            counter_n = '0;
            if (loop_mode) begin
              wrap_n = 1'b1;
            end else begin
              done_n  = 1'b1;
              state_n = IDLE;
            end
          end else begin
            counter_n = counter + ONE_W;
          end
        end
      end

      default: begin
        state_n   = IDLE;
        counter_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state   <= IDLE;
      len_q   <= '0;
      counter <= '0;
      x_out   <= '0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      wrap    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      len_q   <= len_n;
      counter <= counter_n;
      x_out   <= x_out_n;
      x_valid <= x_valid_n;
      busy    <= (state_n == RUN);
      wrap    <= wrap_n;
      done    <= done_n;
    end
  end

endmodule

// File: tb/tb_note_sequence_mux.sv
module tb_note_sequence_mux;

  localparam int DATA_W    = 10;
  localparam int NUM_NOTES = 32;
  localparam int IDX_W     = $clog2(NUM_NOTES + 1);

  logic                        clk_in = 1'b0;
  logic                        rst;
  logic                        start;
  logic                        stop;
  logic                        step_en;
  logic                        loop_mode;
  logic [IDX_W-1:0]            len;
  logic [NUM_NOTES*DATA_W-1:0] x_in_flat;
  logic [DATA_W-1:0]           x_out;
  logic                        x_valid;
  logic [IDX_W-1:0]            counter;
  logic                        busy;
  logic                        wrap;
  logic                        done;

  logic [DATA_W-1:0] slot_val [NUM_NOTES];

  always #5 clk_in = ~clk_in;

  always_comb begin
    for (int k = 0; k < NUM_NOTES; k++) x_in_flat[k*DATA_W +: DATA_W] = slot_val[k];
  end

  note_sequence_mux #(
    .DATA_W(DATA_W),
    .NUM_NOTES(NUM_NOTES)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .start(start),
    .stop(stop),
    .step_en(step_en),
    .loop_mode(loop_mode),
    .len(len),
    .x_in_flat(x_in_flat),
    .x_out(x_out),
    .x_valid(x_valid),
    .counter(counter),
    .busy(busy),
    .wrap(wrap),
    .done(done)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Sequence model: "playing" flag, the active length and the position in
  // the sequence, plus the expected output values.
  bit playing = 0;
  int act_len = 0;
  int pos     = 0;
  int e_x = 0, e_valid = 0, e_wrap = 0, e_done = 0;

  // Pulse tallies observed on the DUT, for the literal scenario checks.
  int n_valid = 0, n_wrap = 0, n_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    e_valid = 0;
    e_wrap  = 0;
    e_done  = 0;
    if (rst) begin
      playing = 0; act_len = 0; pos = 0; e_x = 0;
    end else if (stop) begin
      playing = 0; pos = 0;
    end else if (start) begin
      playing = 1;
      act_len = (len == 0 || int'(len) > NUM_NOTES) ? NUM_NOTES : int'(len);
      pos     = 0;
    end else if (step_en && playing) begin
      e_x     = int'(slot_val[pos]);
      e_valid = 1;
      pos     = (pos + 1) % act_len;
      if (pos == 0) begin
        if (loop_mode) e_wrap = 1;
        else begin e_done = 1; playing = 0; end
      end
    end
  endtask

  task automatic compare();
    check("x_out",   32'(x_out),   32'(e_x));
    check("x_valid", 32'(x_valid), 32'(e_valid));
    check("counter", 32'(counter), 32'(pos));
    check("busy",    32'(busy),    32'(playing));
    check("wrap",    32'(wrap),    32'(e_wrap));
    check("done",    32'(done),    32'(e_done));
    n_valid += int'(x_valid);
    n_wrap  += int'(wrap);
    n_done  += int'(done);
  endtask

  // One clock: model advances on the edge with the inputs the DUT sees,
  // outputs are compared on the falling edge, where new inputs get driven.
  task automatic tick();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
    compare();
  endtask

  task automatic idle_inputs();
    rst = 0; start = 0; stop = 0; step_en = 0;
  endtask

  int v0, w0, d0, peak;

  initial begin
    for (int k = 0; k < NUM_NOTES; k++) slot_val[k] = DATA_W'($urandom);
    rst = 1; start = 1'($urandom); stop = 1'($urandom); step_en = 1'($urandom);
    loop_mode = 1'($urandom); len = IDX_W'($urandom);

    // 1: reset with random inputs
    repeat (2) begin
      tick();
      start = 1'($urandom); stop = 1'($urandom); step_en = 1'($urandom);
      len = IDX_W'($urandom);
    end
    check("rst_x_out", 32'(x_out), 32'd0);
    check("rst_counter", 32'(counter), 32'd0);
    check("rst_flags", {28'd0, x_valid, busy, wrap, done}, 32'd0);

    idle_inputs();
    for (int k = 0; k < NUM_NOTES; k++) slot_val[k] = DATA_W'(100 + k);
    tick();

    // 2: one-shot, len 4
    len = 4; loop_mode = 0; start = 1;
    v0 = n_valid; d0 = n_done;
    tick();
    start = 0; step_en = 1;
    repeat (6) tick();
    step_en = 0;
    tick();
    check("s2_valids", 32'(n_valid - v0), 32'd4);
    check("s2_done", 32'(n_done - d0), 32'd1);
    check("s2_hold", 32'(x_out), 32'd103);
    check("s2_busy", 32'(busy), 32'd0);

    // 3: loop, len 3, then loop_mode dropped mid-run
    len = 3; loop_mode = 1; start = 1;
    v0 = n_valid; w0 = n_wrap; d0 = n_done;
    tick();
    start = 0; step_en = 1;
    repeat (9) tick();
    check("s3_wraps", 32'(n_wrap - w0), 32'd3);
    check("s3_nodone", 32'(n_done - d0), 32'd0);
    check("s3_last", 32'(x_out), 32'd102);
    loop_mode = 0;
    repeat (4) tick();
    step_en = 0;
    tick();
    check("s3_valids", 32'(n_valid - v0), 32'd12);
    check("s3_done", 32'(n_done - d0), 32'd1);

    // 4: len 0 and len 40 both use all 32 slots
    for (int t = 0; t < 2; t++) begin
      len = (t == 0) ? IDX_W'(0) : IDX_W'(40);
      start = 1;
      v0 = n_valid; d0 = n_done; peak = 0;
      tick();
      start = 0; step_en = 1;
      repeat (34) begin
        tick();
        if (int'(counter) > peak) peak = int'(counter);
      end
      step_en = 0;
      tick();
      check("s4_valids", 32'(n_valid - v0), 32'd32);
      check("s4_done", 32'(n_done - d0), 32'd1);
      check("s4_last", 32'(x_out), 32'd131);
      check("s4_peak", 32'(peak), 32'd31);
    end

    // 5: stop+start together aborts; start+step_en drops the step
    len = 8; start = 1;
    d0 = n_done;
    tick();
    start = 0; step_en = 1;
    repeat (2) tick();
    step_en = 0; stop = 1; start = 1;
    tick();
    check("s5_busy", 32'(busy), 32'd0);
    check("s5_hold", 32'(x_out), 32'd101);
    check("s5_nodone", 32'(n_done - d0), 32'd0);
    stop = 0; start = 1; step_en = 1;
    tick();
    check("s5_counter", 32'(counter), 32'd0);
    check("s5_novalid", 32'(x_valid), 32'd0);
    check("s5_run", 32'(busy), 32'd1);
    start = 0;
    repeat (2) tick();
    check("s5_step", 32'(x_out), 32'd101);

    // 6: reset mid-sequence
    step_en = 0; start = 1;
    tick();
    start = 0; step_en = 1;
    repeat (3) tick();
    check("s6_pre", 32'(x_out), 32'd102);
    rst = 1;
    tick();
    check("s6_x_out", 32'(x_out), 32'd0);
    check("s6_counter", 32'(counter), 32'd0);
    check("s6_flags", {28'd0, x_valid, busy, wrap, done}, 32'd0);
    idle_inputs();
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
